reg_write_ctrl: RTL and testbench
=================================

REG_WRITE_CTRL -- requirements
Module: reg_write_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, fixed 8, number of storage words; address width is 3.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 we  input  1  write enable, active-low; sampled on the clk rising edge.
REQ-006 add_wr  input  3  write start address.
REQ-007 wd  input  WIDTH  write data for the current beat.
REQ-008 be  input  WIDTH/8  byte enables, bit i gates wd byte i.
REQ-009 burst_len  input  3  extra beats after the first, 0..7; sampled only at burst start.
REQ-010 REG  output  WIDTH x [7:0]  storage array, drives the 8:1 read mux directly.
REQ-011 busy  output  1  high while a burst beyond the first beat is in progress.
REQ-012 wr_done  output  1  one-cycle pulse after the final beat of a write or burst.
REQ-013 err  output  1  one-cycle pulse on burst abort.

Function
REQ-014 States SHALL be IDLE and BURST only.
REQ-015 IDLE, we=0 at an edge: REG[add_wr] SHALL be updated at that edge, with each byte i taking wd byte i when be[i]=1 and holding its value otherwise.
REQ-016 IDLE start with burst_len=0: SHALL stay IDLE and assert wr_done for the next cycle only.
REQ-017 IDLE start with burst_len=N>0: SHALL latch N as beat counter, latch next address = add_wr+1 modulo 8, enter BURST, and assert busy from the next cycle.
REQ-018 IDLE, we=1: no REG change, no state change; wr_done=0 and err=0 in the following cycle.
REQ-019 BURST, we=0 at an edge: SHALL write wd/be to the latched address, increment the address modulo 8 (7 wraps to 0), and decrement the counter; add_wr and burst_len SHALL be ignored.
REQ-020 BURST, counter reaches 0 on a write: SHALL return to IDLE, deassert busy, and pulse wr_done for the next cycle.
REQ-021 BURST, we=1 at an edge: SHALL abort with no write that edge, return to IDLE, deassert busy, and pulse err for one cycle; wr_done SHALL NOT pulse.
REQ-022 A beat with be all zero SHALL still count as a beat (address advances, counter decrements) with no REG bits changed.
REQ-023 Write latency SHALL be 0 cycles after the sampling edge: the new REG value is visible immediately after the edge at which we=0 was sampled.
REQ-024 A burst with N=7 SHALL write all 8 words exactly once, wrapping as needed.
REQ-025 Back-to-back: in the cycle wr_done is high, IDLE SHALL accept a new write if we=0, and the new write's wr_done SHALL pulse independently.
REQ-026 REG words not addressed by a beat SHALL hold their values.
REQ-027 busy, wr_done, and err SHALL be registered outputs.

Reset
REQ-028 rst=1 at an edge SHALL set all REG words to 0, set state to IDLE, and clear busy, wr_done, err, counter, and the latched address.
REQ-029 rst SHALL take priority over a simultaneous we=0, so no write occurs at that edge.
REQ-030 rst during BURST SHALL terminate the burst with no err and no wr_done pulse.
REQ-031 After rst deasserts, the first edge with we=0 SHALL be accepted as a new IDLE start.

Verification
REQ-032 Single write: add_wr=3, wd=32'hDEADBEEF, be=4'hF, burst_len=0, one cycle of we=0 -> REG[3]=DEADBEEF after the edge; wr_done high for exactly one cycle; busy stays 0.
REQ-033 Byte mask: REG[5]=32'h11223344, then a write of wd=32'hAABBCCDD with be=4'b0101 -> REG[5]=32'h11BB33DD.
REQ-034 Wrapping burst: add_wr=6, burst_len=3, wd sequence 1,2,3,4 with we held low -> REG[6]=1, REG[7]=2, REG[0]=3, REG[1]=4; busy high for 3 cycles; one wr_done pulse.
REQ-035 Abort: add_wr=0, burst_len=5, we raised after 2 beats -> only REG[0] and REG[1] written; err pulses once; no wr_done; state IDLE.
REQ-036 Reset mid-burst: rst=1 during beat 2 of a 4-beat burst -> all REG=0, busy=0, no err/wr_done; a single write afterwards completes normally.
REQ-037 Reset priority: rst=1 and we=0 on the same edge, add_wr=2 -> REG[2]=0 and no wr_done.

Source files
------------

// File: rtl/reg_write_ctrl.sv
// 8-word byte-masked register file with single-beat and burst write sequencing.
// Writes land at the sampling edge (0-cycle latency); we high mid-burst aborts it, no stall path.
module reg_write_ctrl #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         we,
   input  logic [2:0]                   add_wr,
   input  logic [WIDTH-1:0]             wd,
   input  logic [WIDTH/8-1:0]           be,
   input  logic [2:0]                   burst_len,
   output logic [DEPTH-1:0][WIDTH-1:0]  REG,
   output logic                         busy,
   output logic                         wr_done,
   output logic                         err
);

   typedef enum logic {IDLE, BURST} state_t;

   state_t     state, state_d;
   logic [2:0] cnt, cnt_d;
   logic [2:0] addr, addr_d;
   logic       busy_d, done_d, err_d;
   logic       wr_en;
   logic [2:0] wr_addr;

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      addr_d  = addr;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      wr_en   = 1'b0;
      wr_addr = add_wr;
      case (state)
         IDLE: begin
            if (!we) begin
               wr_en   = 1'b1;
               wr_addr = add_wr;
               if (burst_len == 3'd0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = BURST;
                  cnt_d   = burst_len;
                  addr_d  = add_wr + 3'd1;
                  busy_d  = 1'b1;
               end
            end
         end
         BURST: begin
            // add_wr and burst_len are ignored here; the latched address and count drive the beat
            if (!we) begin
               wr_en   = 1'b1;
               wr_addr = addr;
               addr_d  = addr + 3'd1;
               cnt_d   = cnt - 3'd1;
               if (cnt == 3'd1) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  busy_d  = 1'b1;
               end
            end else begin
               state_d = IDLE;
               err_d   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 3'd0;
         addr    <= 3'd0;
         busy    <= 1'b0;
         wr_done <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         addr    <= addr_d;
         busy    <= busy_d;
         wr_done <= done_d;
         err     <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         REG <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < WIDTH/8; i++) begin
            if (be[i]) REG[wr_addr][8*i +: 8] <= wd[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_reg_write_ctrl.sv
// Scoreboard bench for reg_write_ctrl: reference word model plus queue of expected done/err pulses.
module tb_reg_write_ctrl;

   localparam int EV_DONE = 1;
   localparam int EV_ERR  = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             we;
   logic [2:0]       add_wr;
   logic [31:0]      wd;
   logic [3:0]       be;
   logic [2:0]       burst_len;
   logic [7:0][31:0] reg_q;
   logic             busy, wr_done, err;

   logic [31:0] model [8];
   int          exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   reg_write_ctrl #(.WIDTH(32), .DEPTH(8)) dut (
      .clk(clk), .rst(rst), .we(we), .add_wr(add_wr), .wd(wd), .be(be),
      .burst_len(burst_len), .REG(reg_q), .busy(busy), .wr_done(wr_done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic void mwrite(input int a, input logic [31:0] d, input logic [3:0] b);
      for (int i = 0; i < 4; i++) if (b[i]) model[a][8*i +: 8] = d[8*i +: 8];
   endfunction

   function automatic void mclear;
      for (int i = 0; i < 8; i++) model[i] = '0;
   endfunction

   // every done/err pulse must match the oldest expectation queued by the stimulus
   always @(posedge clk) begin
      #2;
      if (wr_done === 1'b1 || err === 1'b1) begin
         n_checks++;
         if (wr_done === 1'b1 && err === 1'b1) begin
            n_fail++;
            $display("FAIL pulse_both: wr_done=%b err=%b, required only one", wr_done, err);
         end else if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL pulse_unexpected: wr_done=%b err=%b, required no pulse", wr_done, err);
         end else begin
            int e;
            int o;
            e = exp_q.pop_front();
            o = wr_done ? EV_DONE : EV_ERR;
            if (o !== e) begin
               n_fail++;
               $display("FAIL pulse_kind: got event %0d, required %0d", o, e);
            end
         end
      end
   end

   task automatic test_reset;
      rst = 1'b1; we = 1'b1; add_wr = '0; wd = '0; be = '0; burst_len = '0;
      step; step;
      rst = 1'b0;
      mclear();
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (reg_q[i] !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_reg%0d: got %h, required 00000000", i, reg_q[i]);
         end
      end
      n_checks++;
      if ({busy, wr_done, err} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags: busy/done/err=%b, required 000", {busy, wr_done, err});
      end
   endtask

   task automatic test_single;
      we = 1'b0; add_wr = 3'd3; wd = 32'hDEADBEEF; be = 4'hF; burst_len = 3'd0;
      mwrite(3, wd, be); exp_q.push_back(EV_DONE);
      step;
      we = 1'b1;
      n_checks++;
      if (reg_q[3] !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL single_reg3: got %h, required deadbeef", reg_q[3]);
      end
      n_checks++;
      if (wr_done !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_flags: wr_done=%b busy=%b, required 1 0", wr_done, busy);
      end
      step;
      n_checks++;
      if (wr_done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_after: wr_done=%b busy=%b, required 0 0", wr_done, busy);
      end
   endtask

   task automatic test_byte_mask;
      we = 1'b0; add_wr = 3'd5; wd = 32'h11223344; be = 4'hF; burst_len = 3'd0;
      mwrite(5, wd, be); exp_q.push_back(EV_DONE);
      step;
      wd = 32'hAABBCCDD; be = 4'b0101;
      mwrite(5, wd, be); exp_q.push_back(EV_DONE);
      step;
      we = 1'b1;
      n_checks++;
      if (reg_q[5] !== 32'h11BB33DD) begin
         n_fail++;
         $display("FAIL byte_mask: got %h, required 11bb33dd", reg_q[5]);
      end
      step;
   endtask

   task automatic test_wrap_burst;
      int busy_cnt;
      busy_cnt = 0;
      for (int k = 0; k < 4; k++) begin
         we = 1'b0; wd = 32'(k + 1); be = 4'hF;
         // after the first beat add_wr/burst_len are garbage that must be ignored
         add_wr    = (k == 0) ? 3'd6 : 3'd3;
         burst_len = (k == 0) ? 3'd3 : 3'd7;
         mwrite((6 + k) % 8, wd, be);
         if (k == 3) exp_q.push_back(EV_DONE);
         step;
         busy_cnt += int'(busy);
      end
      we = 1'b1;
      step;
      busy_cnt += int'(busy);
      n_checks++;
      if (reg_q[6] !== 32'd1 || reg_q[7] !== 32'd2 || reg_q[0] !== 32'd3 || reg_q[1] !== 32'd4) begin
         n_fail++;
         $display("FAIL wrap_burst_data: R6=%h R7=%h R0=%h R1=%h, required 1 2 3 4",
                  reg_q[6], reg_q[7], reg_q[0], reg_q[1]);
      end
      n_checks++;
      if (busy_cnt !== 3) begin
         n_fail++;
         $display("FAIL wrap_burst_busy: busy cycles %0d, required 3", busy_cnt);
      end
   endtask

   task automatic test_abort;
      for (int k = 0; k < 2; k++) begin
         we = 1'b0; add_wr = 3'd0; burst_len = 3'd5; be = 4'hF; wd = 32'hA0A0_0000 + 32'(k);
         mwrite(k, wd, be);
         step;
      end
      we = 1'b1; wd = 32'hFFFF_FFFF;
      exp_q.push_back(EV_ERR);
      step;
      n_checks++;
      if (err !== 1'b1 || wr_done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_flags: err=%b wr_done=%b busy=%b, required 1 0 0", err, wr_done, busy);
      end
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (reg_q[i] !== model[i]) begin
            n_fail++;
            $display("FAIL abort_reg%0d: got %h, required %h", i, reg_q[i], model[i]);
         end
      end
      // a fresh single write must complete at once, showing the FSM is back in IDLE
      we = 1'b0; add_wr = 3'd4; wd = 32'h0BAD_F00D; be = 4'hF; burst_len = 3'd0;
      mwrite(4, wd, be); exp_q.push_back(EV_DONE);
      step;
      we = 1'b1;
      n_checks++;
      if (wr_done !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || reg_q[4] !== 32'h0BAD_F00D) begin
         n_fail++;
         $display("FAIL abort_recover: wr_done=%b busy=%b err=%b R4=%h, required 1 0 0 0badf00d",
                  wr_done, busy, err, reg_q[4]);
      end
      step;
   endtask

   task automatic test_full_burst;
      for (int k = 0; k < 8; k++) begin
         we = 1'b0; add_wr = (k == 0) ? 3'd5 : 3'd1; burst_len = (k == 0) ? 3'd7 : 3'd2;
         wd = $urandom;
         be = (k == 3) ? 4'h0 : 4'hF;
         mwrite((5 + k) % 8, wd, be);
         if (k == 7) exp_q.push_back(EV_DONE);
         step;
      end
      we = 1'b1;
      step;
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (reg_q[i] !== model[i]) begin
            n_fail++;
            $display("FAIL full_burst_reg%0d: got %h, required %h", i, reg_q[i], model[i]);
         end
      end
   endtask

   task automatic test_back_to_back;
      for (int k = 0; k < 3; k++) begin
         we = 1'b0; add_wr = 3'(k + 1); burst_len = 3'd0; be = 4'hF; wd = 32'hC0DE_0000 + 32'(k);
         mwrite(k + 1, wd, be); exp_q.push_back(EV_DONE);
         step;
         n_checks++;
         if (wr_done !== 1'b1 || reg_q[k + 1] !== model[k + 1]) begin
            n_fail++;
            $display("FAIL b2b_%0d: wr_done=%b R=%h, required 1 %h", k, wr_done, reg_q[k + 1], model[k + 1]);
         end
      end
      we = 1'b1;
      step;
   endtask

   task automatic test_reset_mid_burst;
      we = 1'b0; add_wr = 3'd2; burst_len = 3'd3; be = 4'hF; wd = 32'h1234_5678;
      step;
      rst = 1'b1; wd = 32'h8765_4321;
      step;
      rst = 1'b0; we = 1'b1;
      mclear();
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (reg_q[i] !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_burst_reg%0d: got %h, required 00000000", i, reg_q[i]);
         end
      end
      n_checks++;
      if ({busy, wr_done, err} !== 3'b000) begin
         n_fail++;
         $display("FAIL rst_burst_flags: busy/done/err=%b, required 000", {busy, wr_done, err});
      end
      step;
      n_checks++;
      if ({busy, wr_done, err} !== 3'b000) begin
         n_fail++;
         $display("FAIL rst_burst_after: busy/done/err=%b, required 000", {busy, wr_done, err});
      end
      we = 1'b0; add_wr = 3'd7; burst_len = 3'd0; wd = 32'hFACE_CAFE;
      mwrite(7, wd, be); exp_q.push_back(EV_DONE);
      step;
      we = 1'b1;
      n_checks++;
      if (wr_done !== 1'b1 || reg_q[7] !== 32'hFACE_CAFE) begin
         n_fail++;
         $display("FAIL rst_burst_recover: wr_done=%b R7=%h, required 1 facecafe", wr_done, reg_q[7]);
      end
      step;
   endtask

   task automatic test_reset_priority;
      we = 1'b0; add_wr = 3'd2; burst_len = 3'd0; be = 4'hF; wd = 32'h5555_5555;
      exp_q.push_back(EV_DONE);
      step;
      rst = 1'b1; wd = 32'hFFFF_FFFF;
      step;
      rst = 1'b0; we = 1'b1;
      mclear();
      n_checks++;
      if (reg_q[2] !== 32'h0 || wr_done !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_priority: R2=%h wr_done=%b, required 00000000 0", reg_q[2], wr_done);
      end
      step;
   endtask

   initial begin
      test_reset();
      test_single();
      test_byte_mask();
      test_wrap_burst();
      test_abort();
      test_full_burst();
      test_back_to_back();
      test_reset_mid_burst();
      test_reset_priority();
      step; step;
      n_checks++;
      if (exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL pulse_missing: %0d expected pulses never seen, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
